// File: rtl/mux_scan_capture.sv
// -----------------------------------------------------------------------------
// mux_scan_capture
//
// Sequencer and capture stage for an external 8-to-1 single-bit mux. The block
// steps the mux select from 0 to 7. After each select change it waits SETTLE
// cycles, then samples the mux output. The eight samples are packed into a
// byte (bit i = sample taken while sel == i). The byte is then offered
// downstream with a valid/ready handshake.
//
// Parameters
//   SETTLE    : extra wait cycles after each select change before sampling
//               (legal 0..15).
//
// Ports
//   clk       : clock, rising edge.
//   rst_n     : asynchronous active-low reset.
//   start     : request one 8-input scan. Only honoured in IDLE.
//   sel       : registered mux select.
//   q_in      : mux output. Combinational from sel and the mux data inputs.
//   data_out  : last completed word. Kept after the handshake.
//   valid     : data_out holds an unconsumed word.
//   ready     : downstream accepts the word when high together with valid.
//   busy      : high while scanning or holding a word.
// -----------------------------------------------------------------------------
module mux_scan_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] sel,
  input  logic       q_in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e     state_q,   state_d;
  logic [2:0] sel_q,     sel_d;
  logic [3:0] cnt_q,     cnt_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;

  // Next-state logic for the scan sequencer and the capture registers.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    data_d    = data_q;
    valid_d   = valid_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d   = ST_SCAN;
          cnt_d     = SETTLE_C;
          scratch_d = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          scratch_d[sel_q] = q_in;
          if (sel_q != 3'd7) begin
            sel_d = sel_q + 3'd1;
            cnt_d = SETTLE_C;
          end else begin
            // The last sample goes straight into the output word. It must
            // not wait a cycle in scratch first.
            data_d  = scratch_d;
            valid_d = 1'b1;
            sel_d   = 3'd0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // start is deliberately not looked at here. A request on the
        // handshake edge is dropped, not queued.
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        sel_d     = 3'd0;
        cnt_d     = 4'd0;
        scratch_d = 8'h00;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      cnt_q     <= 4'd0;
      scratch_q <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_capture
//
// Directed bench for mux_scan_capture. Two instances share the clock and the
// reset: one with SETTLE=0 and one with SETTLE=3. Each instance has its own
// behavioural 8-to-1 mux model driving q_in. Every expected value below is
// worked out by hand from the scan timing.
// -----------------------------------------------------------------------------
module tb_mux_scan_capture;

  logic       clk;
  logic       rst_n;

  logic       start0, ready0, q0, valid0, busy0;
  logic [2:0] sel0;
  logic [7:0] data0, mux0;

  logic       start3, ready3, q3, valid3, busy3;
  logic [2:0] sel3;
  logic [7:0] data3, mux3;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural muxes: q_in is a combinational function of sel.
  assign q0 = mux0[sel0];
  assign q3 = mux3[sel3];

  mux_scan_capture #(.SETTLE(0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .sel      (sel0),
    .q_in     (q0),
    .data_out (data0),
    .valid    (valid0),
    .ready    (ready0),
    .busy     (busy0)
  );

  mux_scan_capture #(.SETTLE(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .sel      (sel3),
    .q_in     (q3),
    .data_out (data3),
    .valid    (valid3),
    .ready    (ready3),
    .busy     (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then step 1 time unit off it for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; ready0 = 1'b0; mux0 = 8'h00;
    start3 = 1'b0; ready3 = 1'b0; mux3 = 8'h00;

    // ---------------- reset state ----------------
    tick(); tick();
    check_eq("rst_sel0",   32'(sel0),   32'd0);
    check_eq("rst_data0",  32'(data0),  32'h00);
    check_eq("rst_valid0", 32'(valid0), 32'd0);
    check_eq("rst_busy0",  32'(busy0),  32'd0);
    check_eq("rst_busy3",  32'(busy3),  32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- basic scan, SETTLE=0 ----------------
    mux0   = 8'b0100_1101;   // inputs 1..8 = 1,0,1,1,0,0,1,0
    start0 = 1'b1;
    tick();                  // E0
    start0 = 1'b0;
    check_eq("basic_sel_e0",  32'(sel0),  32'd0);
    check_eq("basic_busy_e0", 32'(busy0), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check_eq($sformatf("basic_sel_%0d", c), 32'(sel0), 32'(c));
      check_eq($sformatf("basic_valid_%0d", c), 32'(valid0), 32'd0);
    end
    tick();                  // E0+8
    check_eq("basic_valid", 32'(valid0), 32'd1);
    check_eq("basic_data",  32'(data0),  32'h4D);
    check_eq("basic_sel_h", 32'(sel0),   32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("basic_hold_valid", 32'(valid0), 32'd1);
      check_eq("basic_hold_data",  32'(data0),  32'h4D);
    end
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    check_eq("basic_hs_valid", 32'(valid0), 32'd0);
    check_eq("basic_hs_busy",  32'(busy0),  32'd0);
    check_eq("basic_hs_keep",  32'(data0),  32'h4D);

    // ---------------- settle, SETTLE=3 ----------------
    // Each select is held 4 cycles. Junk is shown first, then the final
    // value is presented before the sampling edge.
    start3 = 1'b1;
    tick();                  // E0
    start3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("settle_sel_%0d_%0d", i, k), 32'(sel3), 32'(i));
        if (i == 7 && k == 3) check_eq("settle_valid_31", 32'(valid3), 32'd0);
        if (k == 0) mux3 = 8'h59;   // junk (inverse of the final word)
        if (k == 2) mux3 = 8'hA6;   // value present at the sampling edge
        tick();
      end
    end
    check_eq("settle_valid_32", 32'(valid3), 32'd1);
    check_eq("settle_data",     32'(data3),  32'hA6);
    check_eq("settle_sel_h",    32'(sel3),   32'd0);
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    check_eq("settle_hs_busy", 32'(busy3), 32'd0);

    // ---------------- handshake, back-to-back, SETTLE=0 ----------------
    mux0   = 8'h3C;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();                  // E0
    check_eq("b2b_busy_e0", 32'(busy0), 32'd1);
    for (int w = 0; w < 2; w++) begin
      for (int c = 1; c <= 10; c++) begin
        tick();              // edge E0 + 10*w + c
        if (c <= 7) check_eq($sformatf("b2b_sel_w%0d_%0d", w, c), 32'(sel0), 32'(c));
        if (c == 4) check_eq($sformatf("b2b_mid_data_w%0d", w), 32'(data0), (w == 0) ? 32'h4D : 32'h3C);
        if (c == 8) begin
          check_eq($sformatf("b2b_valid_w%0d", w), 32'(valid0), 32'd1);
          check_eq($sformatf("b2b_data_w%0d", w), 32'(data0), (w == 0) ? 32'h3C : 32'hC3);
          mux0 = 8'hC3;
        end
        if (c == 9) begin
          check_eq($sformatf("b2b_hs_valid_w%0d", w), 32'(valid0), 32'd0);
          check_eq($sformatf("b2b_hs_busy_w%0d", w), 32'(busy0), 32'd0);
          check_eq($sformatf("b2b_hs_data_w%0d", w), 32'(data0), (w == 0) ? 32'h3C : 32'hC3);
          if (w == 1) start0 = 1'b0;
        end
        if (c == 10) check_eq($sformatf("b2b_restart_w%0d", w), 32'(busy0), (w == 0) ? 32'd1 : 32'd0);
      end
    end
    ready0 = 1'b0;

    // ---------------- ignored start in SCAN and HOLD ----------------
    mux0   = 8'h81;
    start0 = 1'b1;
    tick();                  // E0
    start0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) start0 = 1'b1;
      if (c == 4) start0 = 1'b0;
      check_eq($sformatf("ign_sel_%0d", c), 32'(sel0), (c == 8) ? 32'd0 : 32'(c));
    end
    check_eq("ign_valid", 32'(valid0), 32'd1);
    check_eq("ign_data",  32'(data0),  32'h81);
    start0 = 1'b1;
    tick(); tick();
    start0 = 1'b0;
    check_eq("ign_hold_busy",  32'(busy0),  32'd1);
    check_eq("ign_hold_valid", 32'(valid0), 32'd1);
    check_eq("ign_hold_sel",   32'(sel0),   32'd0);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    check_eq("ign_hs_busy", 32'(busy0), 32'd0);
    tick();
    check_eq("ign_no_rescan", 32'(busy0), 32'd0);

    // ---------------- reset mid-scan, between edges ----------------
    mux0   = 8'hFF;
    start0 = 1'b1;
    tick();                  // E0
    start0 = 1'b0;
    repeat (5) tick();       // bits 0..4 captured
    check_eq("mid_sel5", 32'(sel0), 32'd5);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_sel",   32'(sel0),   32'd0);
    check_eq("mid_rst_data",  32'(data0),  32'h00);
    check_eq("mid_rst_valid", 32'(valid0), 32'd0);
    check_eq("mid_rst_busy",  32'(busy0),  32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("mid_idle_busy", 32'(busy0), 32'd0);
    check_eq("mid_idle_sel",  32'(sel0),  32'd0);
    mux0   = 8'h60;
    start0 = 1'b1;
    tick();                  // E0
    start0 = 1'b0;
    repeat (8) tick();
    check_eq("mid_new_valid", 32'(valid0), 32'd1);
    check_eq("mid_new_data",  32'(data0),  32'h60);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    check_eq("mid_new_hs", 32'(valid0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
